instruction_memory_loader: RTL

Writable instruction store plus its loader: the write-side counterpart of the processor's read-only instruction memory. Accepts a little-endian byte stream over a valid/ready handshake, packs it into 32-bit words, and writes them sequentially from word 0. It serves the fetch stage's combinational `pc -> inst` read port and holds the core while a load is in progress. It sits between the board/testbench programming path and the IF stage.

---
 rtl/instruction_memory_loader_if.sv | 19 +
 rtl/instruction_memory_loader.sv | 130 +++++++++++++
 2 files changed

// File: rtl/instruction_memory_loader_if.sv
// Byte-stream programming port for the instruction store.
// Source drives valid/data; the loader answers with ready.
interface instruction_memory_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

// File: rtl/instruction_memory_loader.sv
// Writable instruction store with a byte-stream loader.
// Packs LE bytes into words, serves a combinational fetch port.
module instruction_memory_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_start,
  input  logic [ADDR_W:0]            load_len,
  instruction_memory_loader_if.slave bs,
  input  logic [31:0]                pc,
  output logic [31:0]                inst,
  output logic                       busy,
  output logic                       loaded,
  output logic                       load_done,
  output logic [ADDR_W:0]            words_written
);

  localparam int LW = ADDR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t state;
  state_t state_n;

  logic [ADDR_W-1:0] wptr;
  logic [1:0]        lane;
  logic [23:0]       asm_q;
  logic [LW-1:0]     len;
  logic [LW-1:0]     eff_len;
  logic [LW-1:0]     ww_inc;
  logic [31:0]       widx;
  logic              fire;
  logic              word_fire;
  logic              last;
  logic              start_go;
  logic              start_zero;

  logic [31:0] mem [DEPTH];

  assign eff_len = (load_len > LW'(DEPTH)) ? LW'(DEPTH) : load_len;
  assign ww_inc  = words_written + LW'(1);

  assign busy          = (state == LOAD);
  assign bs.byte_ready = busy;

  assign fire       = busy & bs.byte_valid;
  assign word_fire  = fire & (lane == 2'd3);
  assign last       = word_fire & (ww_inc == len);
  assign start_go   = ~busy & load_start & (eff_len != '0);
  assign start_zero = ~busy & load_start & (eff_len == '0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next state: enter on a non-empty start, leave on the final word.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start_go) state_n = LOAD;
      LOAD: if (last)     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Session bookkeeping, byte packing and completion flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len           <= '0;
      wptr          <= '0;
      lane          <= '0;
      asm_q         <= '0;
      words_written <= '0;
      loaded        <= 1'b0;
      load_done     <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (start_go) begin
        len           <= eff_len;
        wptr          <= '0;
        lane          <= '0;
        words_written <= '0;
        loaded        <= 1'b0;
      end
      if (start_zero) begin
        words_written <= '0;
        loaded        <= 1'b1;
        load_done     <= 1'b1;
      end
      if (fire) begin
        lane <= lane + 2'd1;
        unique case (lane)
          2'd0: asm_q[7:0]   <= bs.byte_data;
          2'd1: asm_q[15:8]  <= bs.byte_data;
          2'd2: asm_q[23:16] <= bs.byte_data;
          default: ;
        endcase
        if (word_fire) begin
          wptr          <= wptr + 1'b1;
          words_written <= ww_inc;
          if (last) begin
            loaded    <= 1'b1;
            load_done <= 1'b1;
          end
        end
      end
    end
  end

  // Instruction array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (word_fire) mem[wptr] <= {bs.byte_data, asm_q};
  end

  // Fetch port, masked while loading, unloaded or out of range.
  always_comb begin
    widx = pc >> 2;
    inst = 32'h0;
    if (loaded && !busy && widx < 32'(DEPTH))
      inst = mem[widx[ADDR_W-1:0]];
  end

endmodule
